seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seg7_hex_lut.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment helper for the 7-segment scan driver.
// All patterns are stored in active-low form, {g,f,e,d,c,b,a} with bit0 = a.
package seven_seg_pkg;

  // All segments dark (active-low form).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex glyphs; entry 15 first so that SEG_HEX[n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational nibble -> active-low segment pattern.
module seg7_hex_lut
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. One digit per refresh slot, the
// displayed word only changes at frame boundaries, and every slot ends with a
// dead cycle so the anode switch never overlaps the segment change.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [4*NUM_DIGITS-1:0] shown_val_q, shown_val_d;
  logic [NUM_DIGITS-1:0]   shown_dp_q, shown_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc_s, wrap_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic                    zero_run_s;
  logic [NUM_DIGITS-1:0]   an_lit_s;
  logic                    digit_on_s, digit_blank_s, dp_lit_s;
  logic [3:0]              cur_nib_s;
  logic [6:0]              lut_seg_s, seg_al_s;

  assign tc_s      = (pre_cnt_q == PRE_LAST);
  assign wrap_s    = tc_s && (idx_q == IDX_LAST);
  assign cur_nib_s = shown_val_q[4*idx_q +: 4];

  seg7_hex_lut u_lut (
    .nib_i (cur_nib_s),
    .seg_o (lut_seg_s)
  );

  // Next state: prescaler, digit index, pending capture and frame-aligned swap.
  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    shown_val_d  = shown_val_q;
    shown_dp_d   = shown_dp_q;
    frame_done_d = wrap_s;

    if (tc_s) begin
      pre_cnt_d = '0;
      if (wrap_s) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end

    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end

    // A load landing on the boundary itself bypasses the pending stage.
    if (wrap_s) begin
      pend_vld_d = 1'b0;
      if (load) begin
        shown_val_d = value;
        shown_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        shown_val_d = pend_val_q;
        shown_dp_d  = pend_dp_q;
      end else begin
        shown_val_d = shown_val_q;
        shown_dp_d  = shown_dp_q;
      end
    end else begin
      shown_val_d = shown_val_d;
      shown_dp_d  = shown_dp_d;
    end
  end

  // Leading-zero mask: digit i (i>0) is blank when shown nibbles i..N-1 are all zero.
  always_comb begin
    lz_mask_s  = '0;
    zero_run_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s   = zero_run_s && (shown_val_q[4*i +: 4] == 4'h0);
      lz_mask_s[i] = blank_lz && zero_run_s;
    end
  end

  // Output decode: anode select with dead cycle at tc, glyph or blank, polarity.
  always_comb begin
    an_lit_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_lit_s[i] = (idx_q == IDX_W'(i)) && digit_en[i] && !tc_s;
    end
    digit_on_s    = |an_lit_s;
    digit_blank_s = !digit_on_s || lz_mask_s[idx_q];
    seg_al_s      = digit_blank_s ? SEG_BLANK : lut_seg_s;
    dp_lit_s      = !digit_blank_s && shown_dp_q[idx_q];
    an_d          = (AN_ACTIVE_LOW != 0) ? ~an_lit_s : an_lit_s;
    seg_d         = (SEG_ACTIVE_LOW != 0) ? seg_al_s : ~seg_al_s;
    dp_d          = (SEG_ACTIVE_LOW != 0) ? !dp_lit_s : dp_lit_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      shown_val_q  <= '0;
      shown_dp_q   <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      shown_val_q  <= shown_val_d;
      shown_dp_q   <= shown_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (4 digits, 4 clocks per slot, active-low).
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        blank_lz;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0][3:0] exp_an;
  logic [3:0][6:0] exp_seg;
  logic [3:0]      exp_dp;

  seven_seg_scan_driver #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Advance at least one cycle, then stop at the next frame_done pulse.
  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    chk("frame_seen", 32'(frame_done), 32'd1);
  endtask

  // Called in a frame_done cycle; checks the 16 cycles of the following frame.
  task automatic scan_frame(input string tag);
    int d;
    int ph;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      d  = (cyc - 1) / 4;
      ph = (cyc - 1) % 4;
      if (ph < 3) begin
        chk($sformatf("%s_d%0d_an", tag, d), 32'(an), 32'(exp_an[d]));
        if (exp_an[d] != 4'hF) begin
          chk($sformatf("%s_d%0d_seg", tag, d), 32'(seg), 32'(exp_seg[d]));
        end
        chk($sformatf("%s_d%0d_dp", tag, d), 32'(dp), 32'(exp_dp[d]));
      end else begin
        chk($sformatf("%s_d%0d_dead_an", tag, d), 32'(an), 32'h0000_000F);
      end
      chk($sformatf("%s_c%0d_fd", tag, cyc), 32'(frame_done), (cyc == 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    value    = 16'h0000;
    dp_in    = 4'h0;
    digit_en = 4'hF;
    blank_lz = 1'b0;
    load     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'h0000_000F);
    chk("rst_seg", 32'(seg), 32'h0000_007F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (an !== 4'hE && n < 5);
    chk("first_d0_an", 32'(an), 32'h0000_000E);
    chk("first_d0_seg", 32'(seg), 32'h0000_0040);

    // Scan order with 1234
    do_load(16'h1234, 4'h0);
    wait_frame();
    exp_an  = {4'h7, 4'hB, 4'hD, 4'hE};
    exp_seg = {7'h79, 7'h24, 7'h30, 7'h19};
    exp_dp  = 4'b1111;
    scan_frame("scan");

    // Mid-frame load keeps the current frame intact
    repeat (5) tick();
    do_load(16'hABCD, 4'h0);
    repeat (3) tick();
    chk("keep_old_an", 32'(an), 32'h0000_000B);
    chk("keep_old_seg", 32'(seg), 32'h0000_0024);
    repeat (7) tick();
    chk("abcd_fd", 32'(frame_done), 32'd1);
    exp_seg = {7'h08, 7'h03, 7'h46, 7'h21};
    scan_frame("abcd");

    // Load on the wrapping tc goes straight to the next frame and stays
    repeat (15) tick();
    value = 16'h5678;
    dp_in = 4'h0;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    chk("byp_fd", 32'(frame_done), 32'd1);
    exp_seg = {7'h12, 7'h02, 7'h78, 7'h00};
    scan_frame("byp");
    scan_frame("byp2");

    // Leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0040, 4'h0);
    wait_frame();
    exp_seg = {7'h7F, 7'h7F, 7'h19, 7'h40};
    scan_frame("lz40");
    do_load(16'h0000, 4'h0);
    wait_frame();
    exp_seg = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    scan_frame("lz0");

    // Digit enables and decimal points
    blank_lz = 1'b0;
    digit_en = 4'b0101;
    do_load(16'h1234, 4'b0010);
    wait_frame();
    exp_an  = {4'hF, 4'hB, 4'hF, 4'hE};
    exp_seg = {7'h79, 7'h24, 7'h30, 7'h19};
    exp_dp  = 4'b1111;
    scan_frame("en");
    digit_en = 4'hF;
    do_load(16'h1234, 4'b0001);
    wait_frame();
    exp_an = {4'h7, 4'hB, 4'hD, 4'hE};
    exp_dp = 4'b1110;
    scan_frame("dp");

    // Reset mid-scan with a load pending
    do_load(16'h9999, 4'hF);
    repeat (8) tick();
    chk("pre_rst_an", 32'(an), 32'h0000_000B);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_an", 32'(an), 32'h0000_000F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (an !== 4'hE && n < 5);
    chk("mid_rst_d0_an", 32'(an), 32'h0000_000E);
    chk("mid_rst_d0_seg", 32'(seg), 32'h0000_0040);
    wait_frame();
    exp_seg = {7'h40, 7'h40, 7'h40, 7'h40};
    exp_dp  = 4'b1111;
    scan_frame("rst_clr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
